// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter sharing one DATA_MEMORY port between the CPU
// load/store port (C) and the debug/loader port (D), with a bounded grant lock.
module data_mem_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ack,

    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,

    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    output logic [ADDR_W-1:0] mem_Address,
    output logic [DATA_W-1:0] mem_Write_data,
    input  logic [DATA_W-1:0] mem_Read_Data,

    output logic              busy,
    output logic              owner
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_next;

    logic              any_req;
    logic              winner;
    logic              other_req;
    logic              grant;
    logic [HOLD_W-1:0] hold_cnt;

    logic              txn_we_p1;
    logic              txn_lock_p1;
    logic [ADDR_W-1:0] txn_addr_p1;
    logic [DATA_W-1:0] txn_wdata_p1;
    logic              vld_p1;
    logic              vld_p2;

    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] cnt);
        return (cnt >= HOLD_SAT) ? HOLD_SAT : cnt + HOLD_W'(1);
    endfunction

    // The current owner may only be re-granted against a waiting port while its
    // lock is set and it has not yet used up its consecutive-grant budget.
    function automatic logic keep_owner(input logic lock, input logic [HOLD_W-1:0] cnt);
        return lock && (cnt < HOLD_LIMIT);
    endfunction

    always_comb begin
        any_req   = c_req | d_req;
        winner    = d_req;
        if (c_req && d_req)
            winner = keep_owner(txn_lock_p1, hold_cnt) ? owner : ~owner;
        other_req = winner ? c_req : d_req;
        grant     = (state == IDLE) && any_req;
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p1: transaction latched at grant, presented to memory during ACCESS
    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= 1'b1;
            hold_cnt    <= '0;
            txn_we_p1   <= 1'b0;
            txn_lock_p1 <= 1'b0;
        end else if (grant) begin
            owner       <= winner;
            txn_we_p1   <= winner ? d_we   : c_we;
            txn_lock_p1 <= winner ? d_lock : c_lock;
            if ((winner == owner) && other_req)
                hold_cnt <= hold_sat_inc(hold_cnt);
            else
                hold_cnt <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (grant) begin
            txn_addr_p1  <= winner ? d_addr  : c_addr;
            txn_wdata_p1 <= winner ? d_wdata : c_wdata;
        end
    end

    assign vld_p1 = (state == ACCESS);

    assign mem_MemWrite   = vld_p1 &  txn_we_p1;
    assign mem_MemRead    = vld_p1 & ~txn_we_p1;
    assign mem_Address    = vld_p1 ? txn_addr_p1  : '0;
    assign mem_Write_data = vld_p1 ? txn_wdata_p1 : '0;

    // Stage p2: read data captured at the end of ACCESS, ack raised during RESP
    always_ff @(posedge clock) begin
        if (reset) begin
            c_rdata <= '0;
            d_rdata <= '0;
        end else if (vld_p1 && !txn_we_p1) begin
            if (owner)
                d_rdata <= mem_Read_Data;
            else
                c_rdata <= mem_Read_Data;
        end
    end

    assign vld_p2 = (state == RESP);

    assign c_ack = vld_p2 & ~owner;
    assign d_ack = vld_p2 &  owner;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: vector table plus hand sequences, with a scoreboard of
// expected acks checked against a behavioural DATA_MEMORY model.
module tb_data_mem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    logic              clock;
    logic              reset;
    logic              c_req, c_we, c_lock;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata, c_rdata;
    logic              c_ack;
    logic              d_req, d_we, d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              d_ack;
    logic              mem_MemWrite, mem_MemRead;
    logic [ADDR_W-1:0] mem_Address;
    logic [DATA_W-1:0] mem_Write_data, mem_Read_Data;
    logic              busy, owner;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .mem_Address(mem_Address), .mem_Write_data(mem_Write_data),
        .mem_Read_Data(mem_Read_Data),
        .busy(busy), .owner(owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // DATA_MEMORY model: combinational read, write commits on negedge
    logic [DATA_W-1:0] mem_model [0:8191];
    initial for (int i = 0; i < 8192; i++) mem_model[i] = '0;
    always @(negedge clock) if (mem_MemWrite) mem_model[mem_Address] <= mem_Write_data;
    assign mem_Read_Data = mem_model[mem_Address];

    typedef struct {
        bit                port;
        logic [DATA_W-1:0] c_rd;
        logic [DATA_W-1:0] d_rd;
    } sb_ent_t;

    typedef struct {
        bit                port;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_c;
        logic [DATA_W-1:0] exp_d;
    } vec_t;

    sb_ent_t sb[$];
    int      ack_cyc[$];
    int      cyc = 0;
    int      checks = 0;
    int      errors = 0;
    sb_ent_t ent;
    vec_t    vecs[9];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (!busy)
                check("idle_mem_quiet", 32'(mem_MemWrite | mem_MemRead | (|mem_Address) | (|mem_Write_data)), 32'd0);
            if (c_ack || d_ack) begin
                ack_cyc.push_back(cyc);
                check("ack_mem_quiet", 32'(mem_MemWrite | mem_MemRead), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", {30'd0, c_ack, d_ack}, 32'd0);
                end else begin
                    ent = sb.pop_front();
                    check("ack_port", {30'd0, c_ack, d_ack}, ent.port ? 32'd1 : 32'd2);
                    check("ack_owner", 32'(owner), 32'(ent.port));
                    check("c_rdata", c_rdata, ent.c_rd);
                    check("d_rdata", d_rdata, ent.d_rd);
                end
            end
        end
    end

    task automatic drive(input bit port, input bit req, input bit we, input bit lock,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (port) begin
            d_req = req; d_we = we; d_lock = lock; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = req; c_we = we; c_lock = lock; c_addr = addr; c_wdata = wdata;
        end
    endtask

    task automatic wait_ack(input bit port, output bit ok, output int lat);
        ok  = 1'b0;
        lat = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            lat++;
            if (port ? d_ack : c_ack) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(port ? "ack_timeout_d" : "ack_timeout_c", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int lat;
        sb.push_back('{v.port, v.exp_c, v.exp_d});
        drive(v.port, 1'b1, v.we, 1'b0, v.addr, v.wdata);
        wait_ack(v.port, ok, lat);
        if (ok) check("ack_latency", 32'(lat), 32'd3);
        drive(v.port, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clock); #1;
    endtask

    task automatic run_port(input bit port, input int n, input bit we, input bit lock,
                            input logic [ADDR_W-1:0] addr0, input logic [DATA_W-1:0] data0);
        bit ok;
        int lat;
        for (int i = 0; i < n; i++) begin
            drive(port, 1'b1, we, lock, addr0 + ADDR_W'(i), data0 + DATA_W'(i));
            wait_ack(port, ok, lat);
            if (!ok) break;
        end
        drive(port, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd1);
        check("rst_acks", {30'd0, c_ack, d_ack}, 32'd0);
        check("rst_c_rdata", c_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_mem", 32'(mem_MemWrite | mem_MemRead | (|mem_Address) | (|mem_Write_data)), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        bit ok;
        int lat;

        vecs[0] = '{1'b0, 1'b1, 13'd5,    32'h0000_1234, 32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b0, 13'd5,    32'h0,         32'h0000_1234, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b1, 13'd100,  32'hCAFE_F00D, 32'h0000_1234, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b0, 13'd100,  32'h0,         32'h0000_1234, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b1, 13'd8191, 32'hFFFF_FFFF, 32'h0000_1234, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 1'b0, 13'd8191, 32'h0,         32'hFFFF_FFFF, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b1, 13'd0,    32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'hCAFE_F00D};
        vecs[7] = '{1'b1, 1'b0, 13'd0,    32'h0,         32'hFFFF_FFFF, 32'hA5A5_A5A5};
        vecs[8] = '{1'b0, 1'b0, 13'd100,  32'h0,         32'hCAFE_F00D, 32'hA5A5_A5A5};

        reset = 1'b1;
        apply_reset();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Simultaneous reads right after reset: C first, D three cycles later
        apply_reset();
        ack_cyc.delete();
        sb.push_back('{1'b0, 32'h0000_1234, 32'h0000_0000});
        sb.push_back('{1'b1, 32'h0000_1234, 32'hA5A5_A5A5});
        fork
            run_port(1'b0, 1, 1'b0, 1'b0, 13'd5, 32'h0);
            run_port(1'b1, 1, 1'b0, 1'b0, 13'd0, 32'h0);
        join
        @(posedge clock); #1;
        check("contest_ack_count", 32'(ack_cyc.size()), 32'd2);
        if (ack_cyc.size() == 2) check("contest_ack_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);

        // Continuous requests without lock: strict alternation C,D,C,D,C,D
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{1'b0, 32'h0000_1234, (i == 0) ? 32'hA5A5_A5A5 : 32'h1000_0000 + 32'(i - 1)});
            sb.push_back('{1'b1, 32'h0000_1234, 32'h1000_0000 + 32'(i)});
        end
        fork
            run_port(1'b0, 3, 1'b1, 1'b0, 13'd200, 32'h1000_0000);
            run_port(1'b1, 3, 1'b0, 1'b0, 13'd200, 32'h0);
            begin
                for (int k = 0; k < 9; k++) begin
                    @(posedge clock); #2;
                    check("alt_busy", 32'(busy), 32'((k % 3) != 2));
                    check("alt_memwrite", 32'(mem_MemWrite), 32'((k % 6) == 0));
                end
            end
        join
        @(posedge clock); #1;

        // D locks with continuous requests: four D grants, then C, then D again
        for (int i = 0; i < 4; i++) sb.push_back('{1'b1, 32'h0000_1234, 32'h1000_0002});
        sb.push_back('{1'b0, 32'h0000_0002, 32'h1000_0002});
        for (int i = 0; i < 2; i++) sb.push_back('{1'b1, 32'h0000_0002, 32'h1000_0002});
        fork
            run_port(1'b1, 6, 1'b1, 1'b1, 13'd300, 32'h0);
            begin
                @(posedge clock); #1;
                run_port(1'b0, 1, 1'b0, 1'b0, 13'd302, 32'h0);
            end
        join
        @(posedge clock); #1;

        // Requester changes addr/data after grant: latched values reach memory
        sb.push_back('{1'b0, 32'h0000_0002, 32'h1000_0002});
        drive(1'b0, 1'b1, 1'b1, 1'b0, 13'd500, 32'h0000_0055);
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 13'd501, 32'h0000_0066);
        wait_ack(1'b0, ok, lat);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clock); #1;
        run_vec('{1'b0, 1'b0, 13'd500, 32'h0, 32'h0000_0055, 32'h1000_0002});
        run_vec('{1'b0, 1'b0, 13'd501, 32'h0, 32'h0000_0000, 32'h1000_0002});

        // C request raised and dropped while D is busy: never granted, no ack
        sb.push_back('{1'b1, 32'h0000_0000, 32'h0000_1234});
        drive(1'b1, 1'b1, 1'b0, 1'b0, 13'd5, 32'h0);
        @(posedge clock); #1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 13'd7, 32'h0);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        check("dropped_req_d_ack", 32'(d_ack), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (4) begin
            @(posedge clock); #1;
            check("dropped_req_idle", 32'(busy), 32'd0);
        end

        // Reset during ACCESS of a D read: abandoned, d_rdata cleared
        drive(1'b1, 1'b1, 1'b0, 1'b0, 13'd5, 32'h0);
        @(posedge clock); #1;
        check("mid_rst_access", 32'(mem_MemRead), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_d_ack", 32'(d_ack), 32'd0);
        check("mid_rst_d_rdata", d_rdata, 32'd0);
        check("mid_rst_mem", 32'(mem_MemWrite | mem_MemRead | (|mem_Address)), 32'd0);
        check("mid_rst_owner", 32'(owner), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Reset after the write's negedge: the write stays committed
        drive(1'b0, 1'b1, 1'b1, 1'b0, 13'd400, 32'hDEAD_BEEF);
        @(posedge clock);
        @(negedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        check("wr_rst_busy", 32'(busy), 32'd0);
        @(posedge clock); #1;
        run_vec('{1'b0, 1'b0, 13'd400, 32'h0, 32'hDEAD_BEEF, 32'h0000_0000});

        repeat (3) @(posedge clock);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
